// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro ALU_DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_div_start,
  input  logic             i_div_signed,
  input  logic [WIDTH-1:0] i_div_a,
  input  logic [WIDTH-1:0] i_div_b,
  output logic             o_div_busy,
  output logic             o_div_valid,
  output logic [WIDTH-1:0] o_div_quotient,
  output logic [WIDTH-1:0] o_div_remainder
);

  // state | meaning
  // IDLE  | waiting for i_div_start
  // CALC  | one restoring iteration per cycle, WIDTH cycles
  // DONE  | results valid for this one cycle
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, b_mag;
  logic             sign_q, sign_r;

  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic             div_zero, overflow, early_out, special;
  logic [WIDTH:0]   rem_sh, trial;
  logic             q_bit, last_iter;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  always_comb begin
    a_mag_in = (i_div_signed && i_div_a[WIDTH-1]) ? (~i_div_a + WIDTH'(1)) : i_div_a;
    b_mag_in = (i_div_signed && i_div_b[WIDTH-1]) ? (~i_div_b + WIDTH'(1)) : i_div_b;
    div_zero = (i_div_b == '0);
    overflow = i_div_signed && (i_div_a == MIN_VAL) && (i_div_b == '1);
`ifdef ALU_DIV_EARLY_OUT_EN
    early_out = !div_zero && (a_mag_in < b_mag_in);
`else
    early_out = 1'b0;
`endif
    special = div_zero || overflow || early_out;
  end

  // rem < |b| always holds, so the shifted remainder fits in WIDTH+1 bits
  always_comb begin
    rem_sh    = {rem, dvd[WIDTH-1]};
    trial     = rem_sh - {1'b0, b_mag};
    q_bit     = ~trial[WIDTH];
    rem_nxt   = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt   = {dvd[WIDTH-2:0], q_bit};
    last_iter = (cnt == CNT_W'(1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_div_busy  = 1'b0;
    o_div_valid = 1'b0;
    case (state)
      IDLE: if (i_div_start) state_nxt = special ? DONE : CALC;
      CALC: begin
        o_div_busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        o_div_busy  = 1'b1;
        o_div_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt             <= '0;
      rem             <= '0;
      dvd             <= '0;
      b_mag           <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      o_div_quotient  <= '0;
      o_div_remainder <= '0;
    end else begin
      case (state)
        IDLE: if (i_div_start) begin
          sign_q <= i_div_signed && (i_div_a[WIDTH-1] ^ i_div_b[WIDTH-1]);
          sign_r <= i_div_signed && i_div_a[WIDTH-1];
          b_mag  <= b_mag_in;
          dvd    <= a_mag_in;
          rem    <= '0;
          cnt    <= special ? '0 : CNT_W'(WIDTH);
          if (div_zero) begin
            o_div_quotient  <= '1;
            o_div_remainder <= i_div_a;
          end else if (overflow) begin
            o_div_quotient  <= MIN_VAL;
            o_div_remainder <= '0;
          end else if (early_out) begin
            o_div_quotient  <= '0;
            o_div_remainder <= i_div_a;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= quo_nxt;
          cnt <= cnt - CNT_W'(1);
          if (last_iter) begin
            o_div_quotient  <= sign_q ? (~quo_nxt + WIDTH'(1)) : quo_nxt;
            o_div_remainder <= sign_r ? (~rem_nxt + WIDTH'(1)) : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
